i2c_slave_regs: RTL and testbench
=================================

// Module: i2c_slave_regs
// PURPOSE
//  Synthesizable I2C responder (slave) for the other end of the bus driven by i2c_master_top.
//  Holds a byte-wide register file reachable over I2C: a write sets a pointer, then data.
//  A read returns data from the pointer, auto-incrementing. A local side exposes write strobes.
//  The local side also has a read-only port. Open-drain SDA only; no clock stretching.
// PARAMETERS
//  SADR      7'h10  7-bit I2C device address matched after START
//  AW        3      register-file address width; DEPTH = 2**AW bytes
//  FILT      3      glitch-filter length in wb_clk_i cycles; SCL/SDA must be stable this long
// PORTS
//  wb_clk_i      in   1   system clock; must be >= 20x the SCL rate
//  arst_i        in   1   asynchronous reset, active low
//  scl_pad_i     in   1   SCL line (input only)
//  sda_pad_i     in   1   SDA line
//  sda_pad_o     out  1   SDA drive value, constant 0
//  sda_padoen_o  out  1   SDA output enable, active low (0 = pull low)
//  loc_addr_i    in   AW  local read address
//  loc_data_o    out  8   mem[loc_addr_i], combinational
//  wr_stb_o      out  1   one-cycle pulse per byte written over I2C
//  wr_addr_o     out  AW  address of that byte, valid with wr_stb_o
//  wr_data_o     out  8   data of that byte, valid with wr_stb_o
//  busy_o        out  1   1 from START to STOP, 0 otherwise
// BEHAVIOUR
//  Reset (arst_i=0): sda_padoen_o=1, wr_stb_o=0, busy_o=0, ptr=0, FSM=IDLE, mem cleared to 0.
//  Input path: 2-FF synchronizer then FILT-cycle filter. Filtered SCL rise/fall is a 1-cycle event.
//  START: SDA falls while SCL=1. Repeated START is handled the same way, in any state.
//   On START: FSM goes to ADDR, bit counter clears, busy_o=1, SDA is released.
//  STOP: SDA rises while SCL=1. In any state: FSM goes to IDLE, busy_o=0, SDA is released. ptr is kept.
//  Bits are sampled on SCL rise, MSB first. SDA is driven/released on the first cycle after SCL fall.
//  States:
//   IDLE     wait for START.
//   ADDR     shift 8 bits. If [7:1]==SADR, go to ADDR_ACK. Otherwise go to IGNORE (no ACK).
//   ADDR_ACK drive 0 for one SCL period. Then R/W=0 goes to PTR, R/W=1 loads shreg=mem[ptr] and goes to RDATA.
//   PTR      shift 8 bits. ptr <= byte[AW-1:0] (upper bits ignored). Then PTR_ACK.
//   PTR_ACK  drive 0 for one SCL period. Then WDATA.
//   WDATA    shift 8 bits, then go to WACK. On the 8th SCL rise:
//             mem[ptr]<=byte, and wr_stb_o pulses for 1 cycle with wr_addr_o=ptr, wr_data_o=byte.
//   WACK     drive 0 for one SCL period. ptr <= ptr+1, wrapping modulo DEPTH. Then WDATA.
//   RDATA    drive shreg MSB-first: sda_padoen_o = bit (0 drives low, 1 releases). After 8 bits, RACK.
//   RACK     release SDA and sample the master's bit on SCL rise.
//             ACK(0): ptr++ (wrap), shreg=mem[ptr], go to RDATA.
//             NACK(1): ptr++ (wrap), go to IGNORE.
//   IGNORE   SDA released; leave only on START or STOP.
//  ACK timing: SDA goes low after the SCL fall ending bit 8; it is released after the next SCL fall.
//  The register-file write happens only in WDATA. A START/STOP mid-byte discards the partial byte.
//  A write arriving on the same cycle as a local read: loc_data_o shows the old value until the next cycle.
//  Reset mid-transfer releases SDA immediately, even while SCL is high.
//  The slave never drives SDA while SCL=1, except when holding an ACK/data bit through a high phase.
// TESTING
//  1 START, 0x20, 0x01, 0xA5, 0x5A, STOP -> 4 ACKs.
//    wr_stb_o pulses at addr 1 (data A5) and addr 2 (data 5A); mem[1]=A5, mem[2]=5A.
//  2 Then START, 0x20, 0x01, rSTART, 0x21, read with ACK, read with NACK, STOP -> rx A5 then 5A.
//    Afterwards ptr=3 and busy_o=0.
//  3 START, 0x22 (wrong address), 0x55 -> SDA never driven low by slave, no wr_stb_o; busy_o=1 until STOP.
//  4 AW=3: ptr=0x07, write 0x11, 0x22 -> mem[7]=11, mem[0]=22 (wrap); a read at ptr 7 with ACK wraps the same way.
//  5 START then 4 address bits then STOP -> FSM IDLE, no ACK; a following full write transaction succeeds.
//  6 arst_i low during the RDATA low bit -> sda_padoen_o=1 within 1 cycle, all outputs at reset values.
//    Bench: drive i2c_master_top with prer 0x0064, clock wb_clk_i at 50 MHz, pullups on SCL/SDA.

Source files
------------

// File: rtl/i2c_slave_regs.sv
// I2C responder with a byte-wide register file: write sets a pointer then data,
// read streams from the pointer with auto-increment. Open-drain SDA, no clock stretching.
module i2c_slave_regs #(
  parameter logic [6:0] SADR = 7'h10,
  parameter int         AW   = 3,
  parameter int         FILT = 3
) (
  input  logic          wb_clk_i,
  input  logic          arst_i,
  input  logic          scl_pad_i,
  input  logic          sda_pad_i,
  output logic          sda_pad_o,
  output logic          sda_padoen_o,
  input  logic [AW-1:0] loc_addr_i,
  output logic [7:0]    loc_data_o,
  output logic          wr_stb_o,
  output logic [AW-1:0] wr_addr_o,
  output logic [7:0]    wr_data_o,
  output logic          busy_o
);
  localparam int DEPTH = 2 ** AW;
  localparam int CW    = $clog2(FILT) + 1;

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WACK, RDATA, RACK, IGNORE
  } state_t;

  logic [1:0] pad_in;
  logic [1:0] line_f;
  logic [1:0] line_p;
  assign pad_in = {sda_pad_i, scl_pad_i};

  // Index 0 is SCL, index 1 is SDA; each line is synchronised then must hold FILT cycles.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_filt
      logic [1:0]    sync_reg;
      logic [CW-1:0] cnt_reg;
      logic          line_reg;
      logic          line_prev_reg;
      always_ff @(posedge wb_clk_i or negedge arst_i) begin
        if (!arst_i) begin
          sync_reg      <= 2'b11;
          cnt_reg       <= '0;
          line_reg      <= 1'b1;
          line_prev_reg <= 1'b1;
        end else begin
          sync_reg      <= {sync_reg[0], pad_in[gi]};
          line_prev_reg <= line_reg;
          if (sync_reg[1] != line_reg) begin
            if (cnt_reg == CW'(FILT - 1)) begin
              line_reg <= sync_reg[1];
              cnt_reg  <= '0;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end else begin
            cnt_reg <= '0;
          end
        end
      end
      assign line_f[gi] = line_reg;
      assign line_p[gi] = line_prev_reg;
    end
  endgenerate

  logic scl_rise, scl_fall, start_det, stop_det, sda_f;
  assign sda_f     = line_f[1];
  assign scl_rise  = line_f[0] & ~line_p[0];
  assign scl_fall  = ~line_f[0] & line_p[0];
  assign start_det = line_f[0] & line_p[0] & line_p[1] & ~line_f[1];
  assign stop_det  = line_f[0] & line_p[0] & ~line_p[1] & line_f[1];

  state_t        state_reg, state_next;
  logic [2:0]    bit_cnt_reg, bit_cnt_next;
  logic [7:0]    shreg_reg, shreg_next;
  logic [AW-1:0] ptr_reg, ptr_next;
  logic          oe_n_reg, oe_n_next;
  logic          busy_reg, busy_next;
  logic          wr_stb_reg, wr_stb_next;
  logic [AW-1:0] wr_addr_reg, wr_addr_next;
  logic [7:0]    wr_data_reg, wr_data_next;
  logic          mem_we;
  logic [7:0]    mem_reg [DEPTH];

  logic [7:0]    rx_byte;
  logic [AW-1:0] ptr_inc;
  assign rx_byte = {shreg_reg[6:0], sda_f};
  assign ptr_inc = ptr_reg + 1'b1;

  // In the ACK states oe_n_reg doubles as the phase: first SCL fall drives, second fall leaves.
  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    shreg_next   = shreg_reg;
    ptr_next     = ptr_reg;
    oe_n_next    = oe_n_reg;
    busy_next    = busy_reg;
    wr_stb_next  = 1'b0;
    wr_addr_next = wr_addr_reg;
    wr_data_next = wr_data_reg;
    mem_we       = 1'b0;
    if (stop_det) begin
      state_next = IDLE;
      busy_next  = 1'b0;
      oe_n_next  = 1'b1;
    end else if (start_det) begin
      state_next   = ADDR;
      bit_cnt_next = '0;
      busy_next    = 1'b1;
      oe_n_next    = 1'b1;
    end else begin
      case (state_reg)
        ADDR: if (scl_rise) begin
          shreg_next   = rx_byte;
          bit_cnt_next = bit_cnt_reg + 1'b1;
          if (bit_cnt_reg == 3'd7)
            state_next = (rx_byte[7:1] == SADR) ? ADDR_ACK : IGNORE;
        end
        ADDR_ACK: if (scl_fall) begin
          bit_cnt_next = '0;
          if (oe_n_reg) begin
            oe_n_next = 1'b0;
          end else if (shreg_reg[0]) begin
            shreg_next = mem_reg[ptr_reg];
            oe_n_next  = mem_reg[ptr_reg][7];
            state_next = RDATA;
          end else begin
            oe_n_next  = 1'b1;
            state_next = PTR;
          end
        end
        PTR: if (scl_rise) begin
          shreg_next   = rx_byte;
          bit_cnt_next = bit_cnt_reg + 1'b1;
          if (bit_cnt_reg == 3'd7) begin
            ptr_next   = rx_byte[AW-1:0];
            state_next = PTR_ACK;
          end
        end
        PTR_ACK, WACK: if (scl_fall) begin
          bit_cnt_next = '0;
          if (oe_n_reg) begin
            oe_n_next = 1'b0;
          end else begin
            oe_n_next  = 1'b1;
            state_next = WDATA;
            if (state_reg == WACK) ptr_next = ptr_inc;
          end
        end
        WDATA: if (scl_rise) begin
          shreg_next   = rx_byte;
          bit_cnt_next = bit_cnt_reg + 1'b1;
          if (bit_cnt_reg == 3'd7) begin
            mem_we       = 1'b1;
            wr_stb_next  = 1'b1;
            wr_addr_next = ptr_reg;
            wr_data_next = rx_byte;
            state_next   = WACK;
          end
        end
        RDATA: if (scl_fall) begin
          shreg_next   = {shreg_reg[6:0], 1'b0};
          bit_cnt_next = bit_cnt_reg + 1'b1;
          if (bit_cnt_reg == 3'd7) begin
            oe_n_next  = 1'b1;
            state_next = RACK;
          end else begin
            oe_n_next = shreg_reg[6];
          end
        end
        RACK: begin
          if (scl_rise) begin
            ptr_next = ptr_inc;
            if (!sda_f) shreg_next = mem_reg[ptr_inc];
            else        state_next = IGNORE;
          end else if (scl_fall) begin
            // Only reached after an ACK; the NACK path has already left on the rise.
            oe_n_next    = shreg_reg[7];
            bit_cnt_next = '0;
            state_next   = RDATA;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or negedge arst_i) begin
    if (!arst_i) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= '0;
      shreg_reg   <= '0;
      ptr_reg     <= '0;
      oe_n_reg    <= 1'b1;
      busy_reg    <= 1'b0;
      wr_stb_reg  <= 1'b0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      shreg_reg   <= shreg_next;
      ptr_reg     <= ptr_next;
      oe_n_reg    <= oe_n_next;
      busy_reg    <= busy_next;
      wr_stb_reg  <= wr_stb_next;
      wr_addr_reg <= wr_addr_next;
      wr_data_reg <= wr_data_next;
      if (mem_we) mem_reg[ptr_reg] <= rx_byte;
    end
  end

  assign sda_pad_o    = 1'b0;
  assign sda_padoen_o = oe_n_reg;
  assign loc_data_o   = mem_reg[loc_addr_i];
  assign wr_stb_o     = wr_stb_reg;
  assign wr_addr_o    = wr_addr_reg;
  assign wr_data_o    = wr_data_reg;
  assign busy_o       = busy_reg;
endmodule

// File: tb/tb_i2c_slave_regs.sv
// Bit-banged I2C master driving i2c_slave_regs, checked against a register-file/pointer model.
module tb_i2c_slave_regs;
  localparam int         AW    = 3;
  localparam int         DEPTH = 8;
  localparam int         Q     = 12;
  localparam logic [6:0] SADR  = 7'h10;

  logic          clk = 1'b0;
  logic          arst_i;
  logic          m_scl, m_sda;
  logic          sda_line;
  logic          sda_pad_o, sda_padoen_o;
  logic [AW-1:0] loc_addr_i;
  logic [7:0]    loc_data_o;
  logic          wr_stb_o;
  logic [AW-1:0] wr_addr_o;
  logic [7:0]    wr_data_o;
  logic          busy_o;

  always #10 clk = ~clk;
  assign sda_line = m_sda & (sda_padoen_o ? 1'b1 : sda_pad_o);

  i2c_slave_regs #(.SADR(SADR), .AW(AW), .FILT(3)) dut (
    .wb_clk_i(clk), .arst_i(arst_i), .scl_pad_i(m_scl), .sda_pad_i(sda_line),
    .sda_pad_o(sda_pad_o), .sda_padoen_o(sda_padoen_o),
    .loc_addr_i(loc_addr_i), .loc_data_o(loc_data_o),
    .wr_stb_o(wr_stb_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o), .busy_o(busy_o)
  );

  typedef struct packed {logic [AW-1:0] a; logic [7:0] d;} stb_t;
  stb_t stb_log [64];
  int   stb_n = 0;
  int   low_cnt = 0;
  always @(negedge clk) begin
    if (wr_stb_o) begin
      if (stb_n < 64) stb_log[stb_n] = {wr_addr_o, wr_data_o};
      stb_n++;
    end
    if (!sda_padoen_o) low_cnt++;
  end

  int         n_checks = 0, n_fail = 0;
  logic [7:0] mdl_mem [DEPTH];
  int         mdl_ptr;
  stb_t       exp_stb[$];
  int         stb_rd = 0;
  logic [7:0] tx_buf [8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_bit(input logic b, output logic r);
    m_sda = b; wclk(Q); m_scl = 1'b1; wclk(Q); r = sda_line; wclk(Q); m_scl = 1'b0; wclk(Q);
  endtask

  task automatic i2c_start;
    m_sda = 1'b1; wclk(Q); m_scl = 1'b1; wclk(Q); m_sda = 1'b0; wclk(Q); m_scl = 1'b0; wclk(Q);
  endtask

  task automatic i2c_stop;
    m_sda = 1'b0; wclk(Q); m_scl = 1'b1; wclk(Q); m_sda = 1'b1; wclk(Q);
  endtask

  task automatic wr_byte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) i2c_bit(d[i], r);
    i2c_bit(1'b1, r);
    ack = ~r;
  endtask

  task automatic rd_byte(input logic ack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      i2c_bit(1'b1, r);
      d[i] = r;
    end
    i2c_bit(~ack, r);
  endtask

  task automatic txn_write(input logic [7:0] p, input int n);
    logic ack;
    stb_t e;
    i2c_start;
    wr_byte({SADR, 1'b0}, ack); check("wr_addr_ack", 32'(ack), 1);
    check("busy_mid", 32'(busy_o), 1);
    wr_byte(p, ack); check("wr_ptr_ack", 32'(ack), 1);
    mdl_ptr = int'(p) % DEPTH;
    for (int i = 0; i < n; i++) begin
      wr_byte(tx_buf[i], ack); check("wr_data_ack", 32'(ack), 1);
      mdl_mem[mdl_ptr] = tx_buf[i];
      e.a = mdl_ptr[AW-1:0];
      e.d = tx_buf[i];
      exp_stb.push_back(e);
      mdl_ptr = (mdl_ptr + 1) % DEPTH;
    end
    i2c_stop;
    check("busy_after_stop", 32'(busy_o), 0);
  endtask

  task automatic txn_read(input logic set_ptr, input logic [7:0] p, input int n);
    logic ack;
    logic [7:0] d;
    i2c_start;
    if (set_ptr) begin
      wr_byte({SADR, 1'b0}, ack); check("rd_waddr_ack", 32'(ack), 1);
      wr_byte(p, ack); check("rd_ptr_ack", 32'(ack), 1);
      mdl_ptr = int'(p) % DEPTH;
      i2c_start;
    end
    wr_byte({SADR, 1'b1}, ack); check("rd_addr_ack", 32'(ack), 1);
    for (int i = 0; i < n; i++) begin
      rd_byte(i < n - 1, d);
      check("rd_data", 32'(d), 32'(mdl_mem[mdl_ptr]));
      mdl_ptr = (mdl_ptr + 1) % DEPTH;
    end
    i2c_stop;
    check("busy_after_rd", 32'(busy_o), 0);
  endtask

  task automatic check_stb;
    stb_t e;
    check("stb_count", 32'(stb_n - stb_rd), 32'(exp_stb.size()));
    while (exp_stb.size() > 0 && stb_rd < stb_n && stb_rd < 64) begin
      e = exp_stb.pop_front();
      check("stb_entry", 32'(stb_log[stb_rd]), 32'(e));
      stb_rd++;
    end
    exp_stb.delete();
    stb_rd = stb_n;
  endtask

  task automatic check_mem;
    for (int a = 0; a < DEPTH; a++) begin
      loc_addr_i = a[AW-1:0];
      wclk(1);
      check("loc_data", 32'(loc_data_o), 32'(mdl_mem[a]));
    end
  endtask

  initial begin
    #1800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic r, ack;
    int base;
    int n;
    arst_i = 1'b0; m_scl = 1'b1; m_sda = 1'b1; loc_addr_i = '0;
    for (int i = 0; i < DEPTH; i++) mdl_mem[i] = 8'h00;
    mdl_ptr = 0;
    wclk(5);
    check("rst_padoen", 32'(sda_padoen_o), 1);
    check("rst_pad_o", 32'(sda_pad_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_stb", 32'(wr_stb_o), 0);
    arst_i = 1'b1;
    wclk(5);
    check_mem;

    // 1: pointer 1, data A5 5A
    tx_buf[0] = 8'hA5; tx_buf[1] = 8'h5A;
    txn_write(8'h01, 2);
    check_stb;
    check_mem;

    // 2: repeated-START read of two bytes, then continue from the auto-incremented pointer
    txn_read(1'b1, 8'h01, 2);
    txn_read(1'b0, 8'h00, 1);

    // 3: wrong address is ignored but the bus is busy until STOP
    base = low_cnt;
    i2c_start;
    wr_byte(8'h22, ack); check("bad_addr_nack", 32'(ack), 0);
    wr_byte(8'h55, ack); check("bad_data_nack", 32'(ack), 0);
    check("bad_busy", 32'(busy_o), 1);
    check("bad_no_drive", 32'(low_cnt - base), 0);
    i2c_stop;
    check("bad_busy_stop", 32'(busy_o), 0);
    check_stb;

    // 4: pointer wrap on write and read
    tx_buf[0] = 8'h11; tx_buf[1] = 8'h22;
    txn_write(8'h07, 2);
    check_stb;
    check_mem;
    txn_read(1'b1, 8'h07, 2);

    // 5: STOP after four address bits aborts cleanly
    base = low_cnt;
    i2c_start;
    i2c_bit(1'b0, r); i2c_bit(1'b0, r); i2c_bit(1'b1, r); i2c_bit(1'b0, r);
    i2c_stop;
    check("abort_busy", 32'(busy_o), 0);
    check("abort_no_drive", 32'(low_cnt - base), 0);
    check_stb;
    tx_buf[0] = 8'h77;
    txn_write(8'h02, 1);
    check_stb;

    // Randomised write/read pairs
    for (int k = 0; k < 3; k++) begin
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) tx_buf[i] = 8'($urandom_range(0, 255));
      txn_write(8'($urandom_range(0, 255)), n);
      check_stb;
      txn_read(1'b1, 8'($urandom_range(0, 255)), $urandom_range(1, 4));
    end
    check_mem;

    // 6: reset while the slave drives a 0 data bit
    tx_buf[0] = 8'h3C;
    txn_write(8'h04, 1);
    check_stb;
    i2c_start;
    wr_byte({SADR, 1'b0}, ack); check("rst6_addr_ack", 32'(ack), 1);
    wr_byte(8'h04, ack); check("rst6_ptr_ack", 32'(ack), 1);
    i2c_start;
    wr_byte({SADR, 1'b1}, ack); check("rst6_raddr_ack", 32'(ack), 1);
    check("rst6_bit_low", 32'(sda_padoen_o), 0);
    arst_i = 1'b0;
    #1;
    check("rst6_padoen", 32'(sda_padoen_o), 1);
    check("rst6_busy", 32'(busy_o), 0);
    check("rst6_stb", 32'(wr_stb_o), 0);
    check("rst6_wr_addr", 32'(wr_addr_o), 0);
    check("rst6_wr_data", 32'(wr_data_o), 0);
    for (int i = 0; i < DEPTH; i++) mdl_mem[i] = 8'h00;
    mdl_ptr = 0;
    wclk(3);
    arst_i = 1'b1;
    i2c_stop;
    check_mem;
    check_stb;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
